// File: rtl/bwt_pkg.sv
// Shared definitions for the BWT inexact-recursion accelerator.
//   - Field offsets of the InexRecur word {i, z, k, l}.
//   - Bit positions inside the state word (position, complete, hit, reserved).
//   - State encoding of the result-collector FSM.
package bwt_pkg;

  // InexRecur word: {i[31:24], z[23:16], k[15:8], l[7:0]}
  localparam int I_MSB = 31;
  localparam int I_LSB = 24;
  localparam int Z_MSB = 23;
  localparam int Z_LSB = 16;
  localparam int K_MSB = 15;
  localparam int K_LSB = 8;
  localparam int L_MSB = 7;
  localparam int L_LSB = 0;

  // State word: [4:0] position, [5] complete, [6] hit, [17:7] reserved
  localparam int ST_POS_LSB  = 0;
  localparam int ST_POS_MSB  = 4;
  localparam int ST_COMPLETE = 5;
  localparam int ST_HIT      = 6;
  localparam int ST_RSV_LSB  = 7;

  typedef enum logic [1:0] {
    COL_IDLE  = 2'd0,
    COL_SCAN  = 2'd1,
    COL_DRAIN = 2'd2,
    COL_FIN   = 2'd3
  } col_state_e;

endpackage

// File: rtl/bwt_res_fifo.sv
// Synchronous first-word-fall-through FIFO for collected SA intervals.
//   clk, rst     : clock, synchronous active-high reset (empties the FIFO)
//   push, din    : write strobe and data
//   pop          : read strobe (advance head); only issued when not empty
//   dout         : current head entry (meaningful only while !empty)
//   empty, count : occupancy status
// DEPTH must be a power of two (pointers wrap naturally).
module bwt_res_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; emptiness is tracked by count alone, and the
  // consumer masks the head while empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // The producer's credit scheme must never let a push land on a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/bwt_result_collector.sv
// Result collector behind the BWT inexact-recursion FSM. On start it scans
// InexRecur/state entries 0..num_entries-1, keeps entries that are a
// completed hit with k <= l, and streams their (k, l, addr) out on a
// valid/ready interface, then pulses done with the final hit count.
//   clk, rst              : clock, synchronous active-high reset
//   start, num_entries    : scan request and entry count (latched at start)
//   busy, done, hit_count : scan status; hit_count is held until next start
//   rd_en, rd_addr        : shared register-file read port (1-cycle latency)
//   ir_data_i, st_data_i  : returned InexRecur / state words
//   res_valid/ready       : output stream handshake
//   res_k, res_l, res_addr: interval bounds and source entry address
// Build option: define BWT_RESULT_DEDUP_EN to drop an accepted entry whose
// (k,l) repeats the previously pushed (k,l) of the same scan.
module bwt_result_collector
  import bwt_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int IR_W       = 32,
  parameter int ST_W       = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_entries,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] hit_count,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [IR_W-1:0]   ir_data_i,
  input  logic [ST_W-1:0]   st_data_i,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_k,
  output logic [7:0]        res_l,
  output logic [ADDR_W-1:0] res_addr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = 16 + ADDR_W;

  col_state_e        state;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] ptr;
  logic              inflight;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENT_W-1:0]  head;
  logic [7:0]        ret_k;
  logic [7:0]        ret_l;
  logic              accept;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              unused_ok;

  assign ret_k = ir_data_i[K_MSB:K_LSB];
  assign ret_l = ir_data_i[L_MSB:L_LSB];
  assign unused_ok = ^{ir_data_i[I_MSB:I_LSB], ir_data_i[Z_MSB:Z_LSB],
                       st_data_i[ST_W-1:ST_RSV_LSB], st_data_i[ST_POS_MSB:ST_POS_LSB]};

  // A read is only issued if the FIFO can absorb it even if everything
  // already in flight turns out to be a hit.
  assign credit_ok = (32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH);
  assign rd_en     = (state == COL_SCAN) && credit_ok;
  assign rd_addr   = ptr;

  assign accept = inflight && st_data_i[ST_HIT] && st_data_i[ST_COMPLETE] && (ret_k <= ret_l);

`ifdef BWT_RESULT_DEDUP_EN
  logic       last_valid;
  logic [7:0] last_k;
  logic [7:0] last_l;

  assign push = accept && !(last_valid && (last_k == ret_k) && (last_l == ret_l));

  always_ff @(posedge clk) begin
    if (rst || (state == COL_IDLE && start)) begin
      last_valid <= 1'b0;
      last_k     <= '0;
      last_l     <= '0;
    end else if (push) begin
      last_valid <= 1'b1;
      last_k     <= ret_k;
      last_l     <= ret_l;
    end
  end
`else
  assign push = accept;
`endif

  // NOTE: all FSM state and registered outputs use non-blocking assignments
  // so every branch sees the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COL_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_count <= '0;
      cnt_q     <= '0;
      ptr       <= '0;
      inflight  <= 1'b0;
      addr_q    <= '0;
    end else begin
      done     <= 1'b0;
      inflight <= rd_en;
      if (rd_en) addr_q    <= ptr;
      if (push)  hit_count <= hit_count + ADDR_W'(1);

      case (state)
        COL_IDLE: begin
          if (start) begin
            cnt_q     <= num_entries;
            ptr       <= '0;
            hit_count <= '0;
            if (num_entries == '0) begin
              state <= COL_FIN;
              done  <= 1'b1;
            end else begin
              state <= COL_SCAN;
              busy  <= 1'b1;
            end
          end
        end
        COL_SCAN: begin
          if (rd_en) begin
            ptr <= ptr + ADDR_W'(1);
            if (ptr == cnt_q - ADDR_W'(1)) state <= COL_DRAIN;
          end
        end
        COL_DRAIN: begin
          if (!inflight && fifo_empty) begin
            state <= COL_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= COL_IDLE;
        end
      endcase
    end
  end

  bwt_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({ret_k, ret_l, addr_q}),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign res_valid = !fifo_empty;
  assign pop       = res_valid && res_ready;
  assign res_k     = res_valid ? head[ENT_W-1 -: 8]        : '0;
  assign res_l     = res_valid ? head[ENT_W-9 -: 8]        : '0;
  assign res_addr  = res_valid ? head[ADDR_W-1:0]          : '0;

endmodule

// File: tb/tb_bwt_result_collector.sv
// Directed bench for bwt_result_collector with a scoreboard of expected
// (k, l, addr) results built while the register-file tables are loaded.
module tb_bwt_result_collector;

  localparam int ADDR_W     = 12;
  localparam int IR_W       = 32;
  localparam int ST_W       = 18;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] num_entries = '0;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] hit_count;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [IR_W-1:0]   ir_data_i = '0;
  logic [ST_W-1:0]   st_data_i = '0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [7:0]        res_k;
  logic [7:0]        res_l;
  logic [ADDR_W-1:0] res_addr;

  bwt_result_collector #(
    .ADDR_W(ADDR_W), .IR_W(IR_W), .ST_W(ST_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_entries(num_entries),
    .busy(busy), .done(done), .hit_count(hit_count),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .ir_data_i(ir_data_i), .st_data_i(st_data_i),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_k(res_k), .res_l(res_l), .res_addr(res_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Register-file model: 1-cycle read latency. Idle cycles return a word
  // that would pass the filter, so data consumed without a read shows up.
  logic [IR_W-1:0] ir_mem [4096];
  logic [ST_W-1:0] st_mem [4096];

  always @(posedge clk) begin
    if (rd_en) begin
      ir_data_i <= ir_mem[rd_addr];
      st_data_i <= st_mem[rd_addr];
    end else begin
      ir_data_i <= 32'hdead_0102;
      st_data_i <= 18'h00060;
    end
  end

  // Scoreboard
  logic [27:0] exp_q [$];
  int          exp_hits;
  logic        m_last_valid;
  logic [15:0] m_last_kl;

  task automatic new_table();
    exp_q.delete();
    exp_hits     = 0;
    m_last_valid = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ir_mem[i] = $urandom;
      st_mem[i] = '0;
    end
  endtask

  task automatic load_entry(input int addr, input bit hit, input bit comp,
                            input logic [7:0] k, input logic [7:0] l);
    bit keep;
    ir_mem[addr] = {8'(addr), 8'ha5, k, l};
    st_mem[addr] = {11'h2aa, hit, comp, 5'(addr)};
    keep = hit && comp && (k <= l);
`ifdef BWT_RESULT_DEDUP_EN
    if (keep && m_last_valid && (m_last_kl == {k, l})) keep = 1'b0;
    if (keep) begin
      m_last_valid = 1'b1;
      m_last_kl    = {k, l};
    end
`endif
    if (keep) begin
      exp_q.push_back({k, l, 12'(addr)});
      exp_hits++;
    end
  endtask

  // Monitor: samples on the falling edge
  int                cyc = 0;
  int                done_cnt = 0;
  int                rd_cnt = 0;
  int                first_rd_cyc = -1;
  int                first_val_cyc = -1;
  logic [ADDR_W-1:0] first_rd_addr = '0;
  logic [ADDR_W-1:0] last_rd_addr = '0;
  logic              stall_q = 1'b0;
  logic [27:0]       held = '0;

  always @(negedge clk) begin
    logic [27:0] e;
    cyc++;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (rd_en) begin
        if (rd_cnt == 0) begin
          first_rd_addr = rd_addr;
          first_rd_cyc  = cyc;
        end
        last_rd_addr = rd_addr;
        rd_cnt++;
      end
      if (res_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (stall_q) begin
        check("hold_valid", 32'(res_valid), 32'd1);
        check("hold_data", 32'({res_k, res_l, res_addr}), 32'(held));
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          assert (exp_q.size() > 0) else begin
            n_errors++;
            $error("FAIL unexpected_result: observed %0h expected none", {res_k, res_l, res_addr});
          end
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({res_k, res_l, res_addr}), 32'(e));
        end
      end
      stall_q = res_valid && !res_ready;
      held    = {res_k, res_l, res_addr};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_scan(input int n);
    rd_cnt        = 0;
    first_rd_cyc  = -1;
    first_val_cyc = -1;
    num_entries   = ADDR_W'(n);
    start         = 1'b1;
    tick();
    start       = 1'b0;
    num_entries = ADDR_W'($urandom);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done_cnt >= target), 32'd1);
  endtask

  initial begin
    int d0;
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_k", 32'(res_k), 32'd0);
    check("rst_res_l", 32'(res_l), 32'd0);
    check("rst_res_addr", 32'(res_addr), 32'd0);
    rst = 1'b0;
    tick();

    // Basic filtering
    new_table();
    load_entry(0, 1, 1, 8'd3, 8'd7);
    load_entry(1, 0, 1, 8'd1, 8'd2);
    load_entry(2, 1, 1, 8'd9, 8'd4);
    load_entry(3, 1, 1, 8'd5, 8'd5);
    res_ready = 1'b1;
    d0 = done_cnt;
    start_scan(4);
    check("basic_busy", 32'(busy), 32'd1);
    wait_done(d0 + 1, 50, "basic_done");
    check("basic_drained", 32'(exp_q.size()), 32'd0);
    check("basic_hit_count", 32'(hit_count), 32'd2);
    check("basic_first_addr", 32'(first_rd_addr), 32'd0);
    check("basic_latency", 32'(first_val_cyc - first_rd_cyc), 32'd2);
    repeat (5) tick();
    check("basic_sticky_hits", 32'(hit_count), 32'd2);
    check("basic_idle_busy", 32'(busy), 32'd0);

    // Empty scan
    new_table();
    d0 = done_cnt;
    start_scan(0);
    wait_done(d0 + 1, 3, "empty_done");
    check("empty_reads", 32'(rd_cnt), 32'd0);
    check("empty_hit_count", 32'(hit_count), 32'd0);

    // Backpressure
    new_table();
    for (int i = 0; i < 8; i++) load_entry(i, 1, 1, 8'(i + 1), 8'(2 * i + 10));
    res_ready = 1'b0;
    d0 = done_cnt;
    start_scan(8);
    repeat (20) tick();
    check("stall_reads", 32'(rd_cnt), 32'd4);
    check("stall_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    wait_done(d0 + 1, 100, "bp_done");
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_hit_count", 32'(hit_count), 32'd8);
    check("bp_reads", 32'(rd_cnt), 32'd8);

    // Start while busy (pulse during DRAIN)
    new_table();
    for (int i = 0; i < 4; i++) load_entry(i, 1, 1, 8'(i), 8'(i + 3));
    d0 = done_cnt;
    start_scan(4);
    n = 0;
    while (rd_cnt < 4 && n < 50) begin
      tick();
      n++;
    end
    check("drain_reached", 32'(rd_cnt), 32'd4);
    check("drain_busy", 32'(busy), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0 + 1, 50, "busy_start_done");
    repeat (10) tick();
    check("busy_start_one_done", 32'(done_cnt - d0), 32'd1);
    check("busy_start_no_rescan", 32'(rd_cnt), 32'd4);
    check("busy_start_hits", 32'(hit_count), 32'd4);

    // Reset mid-scan
    new_table();
    load_entry(3, 1, 1, 8'd11, 8'd12);
    load_entry(4, 1, 1, 8'd13, 8'd14);
    res_ready = 1'b0;
    d0 = done_cnt;
    start_scan(8);
    n = 0;
    while (!(rd_en && rd_addr == 12'd5) && n < 50) begin
      tick();
      n++;
    end
    check("rst_point_reached", 32'(rd_addr), 32'd5);
    rst = 1'b1;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_res_valid", 32'(res_valid), 32'd0);
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_no_done", 32'(done_cnt), 32'(d0));
    new_table();
    load_entry(3, 1, 1, 8'd11, 8'd12);
    load_entry(4, 1, 1, 8'd13, 8'd14);
    res_ready = 1'b1;
    start_scan(8);
    wait_done(d0 + 1, 50, "rescan_done");
    check("rescan_first_addr", 32'(first_rd_addr), 32'd0);
    check("rescan_hit_count", 32'(hit_count), 32'd2);
    check("rescan_drained", 32'(exp_q.size()), 32'd0);

    // Duplicate intervals
    new_table();
    load_entry(0, 1, 1, 8'd2, 8'd6);
    load_entry(1, 1, 1, 8'd2, 8'd6);
    load_entry(2, 1, 1, 8'd4, 8'd6);
    load_entry(3, 1, 1, 8'd2, 8'd6);
    d0 = done_cnt;
    start_scan(4);
    wait_done(d0 + 1, 50, "dedup_done");
    check("dedup_drained", 32'(exp_q.size()), 32'd0);
`ifdef BWT_RESULT_DEDUP_EN
    check("dedup_hit_count", 32'(hit_count), 32'd3);
`else
    check("dedup_hit_count", 32'(hit_count), 32'd4);
`endif

    // Largest scan: no pointer wrap, last address 4094
    new_table();
    load_entry(4094, 1, 1, 8'd7, 8'd9);
    d0 = done_cnt;
    start_scan(4095);
    wait_done(d0 + 1, 5000, "max_done");
    check("max_reads", 32'(rd_cnt), 32'd4095);
    check("max_last_addr", 32'(last_rd_addr), 32'd4094);
    check("max_hit_count", 32'(hit_count), 32'd1);
    check("max_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bwt_result_collector.md
Name: bwt_result_collector

Overview:
- Downstream stage of the BWT inexact-recursion accelerator FSM.
- Starts when the FSM signals completion. Sequentially scans the InexRecur and state register files, keeps only entries that hold a successful hit, and emits their SA intervals (k,l) on a valid/ready stream to the host/DMA side.
- Reports the total hit count and a done pulse when the scan finishes.

Parameters:
- ADDR_W, 12, register-file address width.
- IR_W, 32, InexRecur word width; packed as {i[31:24], z[23:16], k[15:8], l[7:0]}.
- ST_W, 18, state word width; [4:0] position, [5] complete, [6] hit, [17:7] reserved.
- FIFO_DEPTH, 4, output buffer depth; power of two, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a scan
- num_entries  in  ADDR_W  number of valid entries, addresses 0..num_entries-1
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse at scan end
- hit_count  out  ADDR_W  hits emitted in the current or last scan
- rd_en  out  1  register-file read enable
- rd_addr  out  ADDR_W  read address, shared by both files
- ir_data_i  in  IR_W  InexRecur data, valid 1 cycle after rd_en
- st_data_i  in  ST_W  state data, valid 1 cycle after rd_en
- res_valid  out  1  result valid
- res_ready  in  1  consumer ready
- res_k  out  8  interval low bound
- res_l  out  8  interval high bound
- res_addr  out  ADDR_W  source entry address

Behaviour:
- Reset: the following are all 0 and FIFO is empty:
  - FSM state IDLE
  - busy, done, hit_count
  - rd_en, rd_addr
  - res_valid, res_k, res_l, res_addr
- Reset mid-scan aborts immediately; no done pulse is produced.
- FSM states:
  - IDLE: on start, latch num_entries, clear hit_count and scan pointer, go to SCAN; busy=1 from the next cycle. If the latched count is 0, go to FIN directly.
  - SCAN: assert rd_en with rd_addr=ptr when (fifo_count + inflight) < FIFO_DEPTH; ptr++. After the read of num_entries-1 is issued, go to DRAIN.
  - DRAIN: wait until no read is in flight and the FIFO is empty, then go to FIN.
  - FIN: done=1 for one cycle, busy=0, go to IDLE.
- Read latency is exactly 1 cycle. inflight is a 1-bit register equal to the previous cycle's rd_en.
- Filter, evaluated on the returned data: accept iff st[6]=1, st[5]=1 and k<=l (unsigned).
  - Accepted entries push {k,l,addr} into the FIFO; hit_count increments in the same cycle.
  - The credit check guarantees a push never meets a full FIFO; overflow is a design error (assertion).
- Output handshake:
  - res_* driven from the FIFO head; res_valid = !empty.
  - Pop when res_valid && res_ready.
  - res_* must hold stable while res_valid && !res_ready.
  - Push and pop in the same cycle: count unchanged.
- Throughput: one entry per cycle while res_ready=1. Latency from rd_en to res_valid is 2 cycles (read, then FIFO register).
- start while busy is ignored. start in the FIN cycle is ignored.
- hit_count is sticky after done until the next start.
- num_entries changes after start have no effect.
- num_entries=4095: ptr must not wrap; the last address read is 4094.

Optional Feature:
- Macro: BWT_RESULT_DEDUP_EN.
- Defined: an accepted entry whose (k,l) equals the last pushed (k,l) in the same scan is dropped and does not increment hit_count. The last-pushed register is invalidated at start.
- Undefined: every accepted entry is emitted.

Decomposition:
- Shared package bwt_pkg holds:
  - field offsets for the IR word (I_MSB/LSB, Z, K, L);
  - state bit positions ST_POS_LSB/MSB, ST_COMPLETE=5, ST_HIT=6;
  - collector FSM state encoding.
- One sub-module: bwt_res_fifo, a synchronous FIFO (FIFO_DEPTH, width 8+8+ADDR_W) with count output.

Test Plan:
- Basic filtering:
  - Stimulus: num_entries=4; entries 0..3 st = {hit,complete} 11, 01, 11, 11; (k,l) = (3,7), (1,2), (9,4), (5,5); res_ready=1.
  - Required: outputs (3,7,addr0) and (5,5,addr3) only; hit_count=2; done pulse ends the scan.
- Empty scan:
  - Stimulus: num_entries=0, start.
  - Required: no rd_en; done pulses within 3 cycles; hit_count=0.
- Backpressure:
  - Stimulus: 8 hit entries; res_ready=0 for 20 cycles, then 1.
  - Required: rd_en stalls after at most 4 reads; res_* stable while stalled; all 8 results delivered in order; hit_count=8.
- Reset mid-scan:
  - Stimulus: rst during SCAN at ptr=5.
  - Required: next cycle busy=0, res_valid=0, no done pulse; a new start rescans from addr 0.
- Start while busy:
  - Stimulus: start pulse during DRAIN.
  - Required: ignored; exactly one done pulse.
- DEDUP_EN:
  - Stimulus: hit entries (2,6), (2,6), (4,6), (2,6).
  - Required with macro: 3 outputs, hit_count=3. Required without macro: 4 outputs.
